// File: rtl/ex_alu_addr_mux_pkg.sv
// Shared definitions for the EX-stage datapath: widths, ALU operation codes,
// next-PC select codes and the unsigned-compare decode used by the ALU.
package ex_alu_addr_mux_pkg;
  localparam int XLEN    = 32;
  localparam int ALU_NUM = 5;

  localparam logic [4:0] ALUOP_NOP   = 5'd0;
  localparam logic [4:0] ALUOP_LUI   = 5'd1;
  localparam logic [4:0] ALUOP_AUIPC = 5'd2;
  localparam logic [4:0] ALUOP_ADD   = 5'd3;
  localparam logic [4:0] ALUOP_SUB   = 5'd4;
  localparam logic [4:0] ALUOP_BNE   = 5'd5;
  localparam logic [4:0] ALUOP_BLT   = 5'd6;
  localparam logic [4:0] ALUOP_BGE   = 5'd7;
  localparam logic [4:0] ALUOP_BLTU  = 5'd8;
  localparam logic [4:0] ALUOP_BGEU  = 5'd9;
  localparam logic [4:0] ALUOP_SLT   = 5'd10;
  localparam logic [4:0] ALUOP_SLTU  = 5'd11;
  localparam logic [4:0] ALUOP_XOR   = 5'd12;
  localparam logic [4:0] ALUOP_OR    = 5'd13;
  localparam logic [4:0] ALUOP_AND   = 5'd14;
  localparam logic [4:0] ALUOP_SLL   = 5'd15;
  localparam logic [4:0] ALUOP_SRL   = 5'd16;
  localparam logic [4:0] ALUOP_SRA   = 5'd17;

  localparam logic [2:0] PCSRC_PC4  = 3'd0;
  localparam logic [2:0] PCSRC_JAL  = 3'd1;
  localparam logic [2:0] PCSRC_JALR = 3'd2;
  localparam logic [2:0] PCSRC_BEQ  = 3'd3;
  localparam logic [2:0] PCSRC_BNE  = 3'd4;
  localparam logic [2:0] PCSRC_BLT  = 3'd5;
  localparam logic [2:0] PCSRC_BGE  = 3'd6;
  localparam logic [2:0] PCSRC_SEQ  = 3'd7;

  // The less flag is unsigned only for bltu, bgeu and sltu.
  function automatic logic is_unsigned_cmp(input logic [4:0] op);
    return (op == ALUOP_BLTU) || (op == ALUOP_BGEU) || (op == ALUOP_SLTU);
  endfunction
endpackage

// File: rtl/ex_alu_addr_mux_if.sv
// EX-stage operand and next-PC bus; master drives pipeline-register values,
// slave is the EX datapath returning operand, result, flags and next PC.
interface ex_alu_addr_mux_if;
  import ex_alu_addr_mux_pkg::*;

  logic [XLEN-1:0] A;
  logic [XLEN-1:0] RD2;
  logic [XLEN-1:0] immout;
  logic [2:0]      ALUSrc;
  logic [4:0]      ALUOp;
  logic [2:0]      PCSrc;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] PCAddr;
  logic [XLEN-1:0] OffsetAddr;
  logic            Zero_m;
  logic            less_m;
  logic [XLEN-1:0] B;
  logic [XLEN-1:0] C;
  logic            Zero;
  logic            less;
  logic [XLEN-1:0] Addr;
  logic            taken;

  modport master (
    output A, RD2, immout, ALUSrc, ALUOp, PCSrc, result, PCAddr, OffsetAddr,
           Zero_m, less_m,
    input  B, C, Zero, less, Addr, taken
  );

  modport slave (
    input  A, RD2, immout, ALUSrc, ALUOp, PCSrc, result, PCAddr, OffsetAddr,
           Zero_m, less_m,
    output B, C, Zero, less, Addr, taken
  );
endinterface

// File: rtl/ex_alu_addr_mux_alu_core.sv
// RV32I ALU: result, zero flag and less-than flag for the EX stage.
module ex_alu_addr_mux_alu_core
  import ex_alu_addr_mux_pkg::*;
(
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] c,
  output logic            zero,
  output logic            less
);

  logic [4:0] shamt_s;
  logic       lt_signed_s;
  logic       lt_unsigned_s;

  assign shamt_s       = b[4:0];
  assign lt_signed_s   = ($signed(a) < $signed(b));
  assign lt_unsigned_s = (a < b);

  // Operation decode; unused codes produce zero.
  always_comb begin
    c = 32'h0000_0000;
    case (alu_op)
      ALUOP_NOP:   c = 32'h0000_0000;
      ALUOP_LUI:   c = b;
      ALUOP_AUIPC,
      ALUOP_ADD:   c = a + b;
      ALUOP_SUB,
      ALUOP_BNE,
      ALUOP_BLT,
      ALUOP_BGE,
      ALUOP_BLTU,
      ALUOP_BGEU:  c = a - b;
      ALUOP_SLT:   c = {31'b0, lt_signed_s};
      ALUOP_SLTU:  c = {31'b0, lt_unsigned_s};
      ALUOP_XOR:   c = a ^ b;
      ALUOP_OR:    c = a | b;
      ALUOP_AND:   c = a & b;
      ALUOP_SLL:   c = a << shamt_s;
      ALUOP_SRL:   c = a >> shamt_s;
      ALUOP_SRA:   c = $unsigned($signed(a) >>> shamt_s);
      default:     c = 32'h0000_0000;
    endcase
  end

  // Flags derived from the result and the compare mode of the operation.
  always_comb begin
    zero = (c == 32'h0000_0000);
    if (is_unsigned_cmp(alu_op)) begin
      less = lt_unsigned_s;
    end else begin
      less = lt_signed_s;
    end
  end

endmodule

// File: rtl/ex_alu_addr_mux.sv
// EX stage of the 5-stage RV32I pipeline: operand mux, ALU, next-PC mux and a
// clocked debug sequencer that walks the EX operands onto the 7-seg display.
module ex_alu_addr_mux
  import ex_alu_addr_mux_pkg::*;
#(
  parameter int ALU_NUM_P = ALU_NUM
)
(
  input  logic            Clk_CPU,
  input  logic            rstn,
  input  logic            dbg_en,
  ex_alu_addr_mux_if.slave bus,
  output logic [XLEN-1:0] alu_disp_data
);

  logic [2:0]      ptr_r;
  logic [2:0]      idx_s;
  logic [XLEN-1:0] slot_s;
  logic            branch_ok_s;
  logic            unused_s;

  assign unused_s = ^{bus.ALUSrc[2:1], bus.result[0]};

  // Second operand: immediate or rs2.
  always_comb begin
    if (bus.ALUSrc[0]) begin
      bus.B = bus.immout;
    end else begin
      bus.B = bus.RD2;
    end
  end

  ex_alu_addr_mux_alu_core u_alu_core (
    .alu_op (bus.ALUOp),
    .a      (bus.A),
    .b      (bus.B),
    .c      (bus.C),
    .zero   (bus.Zero),
    .less   (bus.less)
  );

  // Next-PC select; branches resolve on the flags registered in EX/MEM.
  always_comb begin
    branch_ok_s = 1'b0;
    bus.Addr    = bus.PCAddr;
    bus.taken   = 1'b0;
    case (bus.PCSrc)
      PCSRC_JAL: begin
        bus.Addr  = bus.OffsetAddr;
        bus.taken = 1'b1;
      end
      PCSRC_JALR: begin
        bus.Addr  = {bus.result[31:1], 1'b0};
        bus.taken = 1'b1;
      end
      PCSRC_BEQ: branch_ok_s = bus.Zero_m;
      PCSRC_BNE: branch_ok_s = ~bus.Zero_m;
      PCSRC_BLT: branch_ok_s = bus.less_m;
      PCSRC_BGE: branch_ok_s = ~bus.less_m;
      default:   branch_ok_s = 1'b0;
    endcase
    if (branch_ok_s) begin
      bus.Addr  = bus.OffsetAddr;
      bus.taken = 1'b1;
    end else begin
      bus.Addr  = bus.Addr;
      bus.taken = bus.taken;
    end
  end

  // Wrap the pointer before use so a full sequence restarts at slot 0.
  always_comb begin
    if (ptr_r == 3'(ALU_NUM_P)) begin
      idx_s = 3'd0;
    end else begin
      idx_s = ptr_r;
    end
    case (idx_s)
      3'd0:    slot_s = bus.A;
      3'd1:    slot_s = bus.B;
      3'd2:    slot_s = bus.C;
      3'd3:    slot_s = {31'b0, bus.Zero};
      3'd4:    slot_s = 32'hFFFF_FFFF;
      default: slot_s = 32'h0000_0000;
    endcase
  end

  // Debug sequencer state and registered display word.
  always_ff @(posedge Clk_CPU or negedge rstn) begin
    if (!rstn) begin
      ptr_r         <= 3'd0;
      alu_disp_data <= 32'h0000_0000;
    end else if (dbg_en) begin
      ptr_r         <= idx_s + 3'd1;
      alu_disp_data <= slot_s;
    end else begin
      ptr_r         <= ptr_r;
      alu_disp_data <= alu_disp_data;
    end
  end

endmodule

// File: tb/tb_ex_alu_addr_mux.sv
// Directed bench for the EX-stage datapath and debug display sequencer.
module tb_ex_alu_addr_mux;
  logic        Clk_CPU;
  logic        rstn;
  logic        dbg_en;
  logic [31:0] alu_disp_data;
  int          n_vec;
  int          n_err;

  ex_alu_addr_mux_if bus ();

  ex_alu_addr_mux dut (
    .Clk_CPU       (Clk_CPU),
    .rstn          (rstn),
    .dbg_en        (dbg_en),
    .bus           (bus),
    .alu_disp_data (alu_disp_data)
  );

  initial Clk_CPU = 1'b0;
  always #5 Clk_CPU = ~Clk_CPU;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One enabled debug edge, sampled 1 time unit after the rising edge.
  task automatic dbg_step(input string tag, input logic [31:0] exp);
    @(negedge Clk_CPU);
    dbg_en = 1'b1;
    @(posedge Clk_CPU);
    #1;
    dbg_en = 1'b0;
    chk(tag, alu_disp_data, exp);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn = 1'b0;
    dbg_en = 1'b0;
    bus.A = 32'd0; bus.RD2 = 32'd0; bus.immout = 32'd0;
    bus.ALUSrc = 3'd0; bus.ALUOp = 5'd0; bus.PCSrc = 3'd0;
    bus.result = 32'd0; bus.PCAddr = 32'd0; bus.OffsetAddr = 32'd0;
    bus.Zero_m = 1'b0; bus.less_m = 1'b0;
    #12;
    chk("reset_disp", alu_disp_data, 32'h0);

    // add with register operand
    bus.A = 32'd5; bus.RD2 = 32'd7; bus.ALUSrc = 3'd0; bus.ALUOp = 5'd3; #1;
    chk("add_B", bus.B, 32'd7);
    chk("add_C", bus.C, 32'd12);
    chk("add_Zero", {31'b0, bus.Zero}, 32'd0);

    // sub / slt / sltu with immediate; ALUSrc upper bits must be ignored
    bus.A = 32'hFFFF_FFFF; bus.immout = 32'd1; bus.RD2 = 32'd99; bus.ALUSrc = 3'd7;
    bus.ALUOp = 5'd4; #1;
    chk("sub_B", bus.B, 32'd1);
    chk("sub_C", bus.C, 32'hFFFF_FFFE);
    chk("sub_less", {31'b0, bus.less}, 32'd1);
    bus.ALUOp = 5'd10; #1;
    chk("slt_C", bus.C, 32'd1);
    bus.ALUOp = 5'd11; #1;
    chk("sltu_C", bus.C, 32'd0);
    chk("sltu_less", {31'b0, bus.less}, 32'd0);
    bus.ALUOp = 5'd8; #1;
    chk("bltu_less", {31'b0, bus.less}, 32'd0);

    // shifts use B[4:0] only
    bus.A = 32'h8000_0000; bus.RD2 = 32'h21; bus.ALUSrc = 3'd0;
    bus.ALUOp = 5'd17; #1;
    chk("sra_C", bus.C, 32'hC000_0000);
    bus.ALUOp = 5'd16; #1;
    chk("srl_C", bus.C, 32'h4000_0000);
    bus.ALUOp = 5'd15; #1;
    chk("sll_C", bus.C, 32'h0);
    chk("sll_Zero", {31'b0, bus.Zero}, 32'd1);

    // logic ops, lui, reserved code
    bus.A = 32'hF0F0_F0F0; bus.RD2 = 32'h0FF0_0FF0;
    bus.ALUOp = 5'd12; #1; chk("xor_C", bus.C, 32'hFF00_FF00);
    bus.ALUOp = 5'd13; #1; chk("or_C", bus.C, 32'hFFF0_FFF0);
    bus.ALUOp = 5'd14; #1; chk("and_C", bus.C, 32'h00F0_00F0);
    bus.ALUOp = 5'd1;  #1; chk("lui_C", bus.C, 32'h0FF0_0FF0);
    bus.ALUOp = 5'd20; #1; chk("rsv_C", bus.C, 32'h0);

    // next-PC select
    bus.OffsetAddr = 32'h100; bus.PCAddr = 32'h14;
    bus.PCSrc = 3'd3; bus.Zero_m = 1'b1; #1;
    chk("beq_t_Addr", bus.Addr, 32'h100);
    chk("beq_t_taken", {31'b0, bus.taken}, 32'd1);
    bus.Zero_m = 1'b0; #1;
    chk("beq_n_Addr", bus.Addr, 32'h14);
    chk("beq_n_taken", {31'b0, bus.taken}, 32'd0);
    bus.PCSrc = 3'd4; #1;
    chk("bne_t_Addr", bus.Addr, 32'h100);
    bus.PCSrc = 3'd5; bus.less_m = 1'b1; #1;
    chk("blt_t_Addr", bus.Addr, 32'h100);
    bus.PCSrc = 3'd6; #1;
    chk("bge_n_Addr", bus.Addr, 32'h14);
    chk("bge_n_taken", {31'b0, bus.taken}, 32'd0);
    bus.PCSrc = 3'd1; #1;
    chk("jal_Addr", bus.Addr, 32'h100);
    chk("jal_taken", {31'b0, bus.taken}, 32'd1);
    bus.PCSrc = 3'd2; bus.result = 32'h203; #1;
    chk("jalr_Addr", bus.Addr, 32'h202);
    chk("jalr_taken", {31'b0, bus.taken}, 32'd1);
    bus.PCSrc = 3'd7; #1;
    chk("seq_Addr", bus.Addr, 32'h14);
    chk("seq_taken", {31'b0, bus.taken}, 32'd0);

    // debug sequencer: A=5, B=7, C=12, Zero=0
    bus.A = 32'd5; bus.RD2 = 32'd7; bus.ALUSrc = 3'd0; bus.ALUOp = 5'd3;
    @(negedge Clk_CPU);
    rstn = 1'b1;
    dbg_step("dbg0_A", 32'd5);
    dbg_step("dbg1_B", 32'd7);
    dbg_step("dbg2_C", 32'd12);
    dbg_step("dbg3_Zero", 32'd0);
    dbg_step("dbg4_ones", 32'hFFFF_FFFF);
    dbg_step("dbg5_wrapA", 32'd5);
    @(posedge Clk_CPU); #1;
    chk("dbg_hold", alu_disp_data, 32'd5);
    dbg_step("dbg6_B", 32'd7);

    // asynchronous reset mid-run restarts at slot 0
    @(negedge Clk_CPU);
    rstn = 1'b0; #1;
    chk("dbg_rst", alu_disp_data, 32'h0);
    @(negedge Clk_CPU);
    rstn = 1'b1;
    dbg_step("dbg_rst_A", 32'd5);
    dbg_step("dbg_rst_B", 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
